// File: rtl/apb_slave_responder.sv
// ----------------------------------------------------------------------------
// apb_slave_responder
//
// APB3 completer with a word-addressed register bank, a programmable
// wait-state generator, PSLVERR for bad addresses and saturating per-transfer
// statistics counters.
//
// Ports
//   clk       : single clock, all state on the rising edge
//   rst       : asynchronous, active-high reset
//   psel      : APB select
//   penable   : APB enable (access phase)
//   pwrite    : 1 = write, 0 = read
//   paddr     : byte address
//   pwdata    : write data
//   cfg_wait  : wait states to insert, sampled in the setup cycle
//   prdata    : read data (0 unless completing a good read)
//   pready    : transfer completes this cycle
//   pslverr   : error response, only ever high together with pready
//   wr_cnt    : successful writes (saturating)
//   rd_cnt    : successful reads (saturating)
//   err_cnt   : error responses (saturating)
// ----------------------------------------------------------------------------
module apb_slave_responder #(
   parameter int                    ADDR_WIDTH = 32,
   parameter int                    DATA_WIDTH = 32,
   parameter int                    DEPTH      = 16,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
   parameter int                    CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  psel,
   input  logic                  penable,
   input  logic                  pwrite,
   input  logic [ADDR_WIDTH-1:0] paddr,
   input  logic [DATA_WIDTH-1:0] pwdata,
   input  logic [3:0]            cfg_wait,
   output logic [DATA_WIDTH-1:0] prdata,
   output logic                  pready,
   output logic                  pslverr,
   output logic [CNT_WIDTH-1:0]  wr_cnt,
   output logic [CNT_WIDTH-1:0]  rd_cnt,
   output logic [CNT_WIDTH-1:0]  err_cnt
);

   localparam int IDX_W = $clog2(DEPTH);

   typedef enum logic {
      IDLE,
      ACCESS
   } state_t;

   state_t                  state_reg, state_next;
   logic [3:0]              wcnt_reg, wcnt_next;
   logic                    write_reg;
   logic [ADDR_WIDTH-1:0]   addr_reg;
   logic [DATA_WIDTH-1:0]   wdata_reg;
   logic [DATA_WIDTH-1:0]   mem_reg [DEPTH];
   logic [CNT_WIDTH-1:0]    wr_cnt_reg, rd_cnt_reg, err_cnt_reg;

   logic                    latch_en;
   logic                    done;
   logic [ADDR_WIDTH-1:0]   off;
   logic [IDX_W-1:0]        idx;
   logic                    addr_err;
   logic                    wr_en;

   // ------------------------------------------------------------------------
   // FSM next-state logic
   // ------------------------------------------------------------------------
   always_comb begin
      state_next = state_reg;
      wcnt_next  = wcnt_reg;
      latch_en   = 1'b0;
      done       = 1'b0;
      case (state_reg)
         IDLE: begin
            // psel with penable already high is a protocol violation: ignore it
            if (psel && !penable) begin
               latch_en   = 1'b1;
               wcnt_next  = cfg_wait;
               state_next = ACCESS;
            end
         end
         ACCESS: begin
            if (!psel) begin
               // master abort: drop the transfer without committing anything
               state_next = IDLE;
               wcnt_next  = '0;
            end else if (wcnt_reg != 4'd0) begin
               wcnt_next = wcnt_reg - 4'd1;
            end else begin
               done       = 1'b1;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= IDLE;
         wcnt_reg  <= '0;
         write_reg <= 1'b0;
         addr_reg  <= '0;
         wdata_reg <= '0;
      end else begin
         state_reg <= state_next;
         wcnt_reg  <= wcnt_next;
         if (latch_en) begin
            write_reg <= pwrite;
            addr_reg  <= paddr;
            wdata_reg <= pwdata;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Address decode on the latched address. BASE_ADDR is aligned to the
   // window size, so any set bit above the index field means out of range.
   // ------------------------------------------------------------------------
   always_comb begin
      off      = addr_reg - BASE_ADDR;
      idx      = off[IDX_W+1:2];
      addr_err = (addr_reg < BASE_ADDR)
               || (|off[ADDR_WIDTH-1:IDX_W+2])
               || (off[1:0] != 2'b00);
   end

   assign wr_en   = done && write_reg && !addr_err;
   assign pready  = done;
   assign pslverr = done && addr_err;
   assign prdata  = (done && !write_reg && !addr_err) ? mem_reg[idx] : '0;

   // ------------------------------------------------------------------------
   // Register bank: one resettable word per entry
   // ------------------------------------------------------------------------
   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_bank
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               mem_reg[gi] <= '0;
            end else if (wr_en && (idx == IDX_W'(gi))) begin
               mem_reg[gi] <= wdata_reg;
            end
         end
      end
   endgenerate

   // ------------------------------------------------------------------------
   // Saturating statistics counters, updated on the completion edge
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_cnt_reg  <= '0;
         rd_cnt_reg  <= '0;
         err_cnt_reg <= '0;
      end else if (done) begin
         if (addr_err) begin
            if (err_cnt_reg != '1) err_cnt_reg <= err_cnt_reg + CNT_WIDTH'(1);
         end else if (write_reg) begin
            if (wr_cnt_reg != '1) wr_cnt_reg <= wr_cnt_reg + CNT_WIDTH'(1);
         end else begin
            if (rd_cnt_reg != '1) rd_cnt_reg <= rd_cnt_reg + CNT_WIDTH'(1);
         end
      end
   end

   assign wr_cnt  = wr_cnt_reg;
   assign rd_cnt  = rd_cnt_reg;
   assign err_cnt = err_cnt_reg;

endmodule

// File: tb/tb_apb_slave_responder.sv
// ----------------------------------------------------------------------------
// tb_apb_slave_responder
//
// Directed bench for apb_slave_responder. Register window at 0x1000, 16 words.
// Counters are built 8 bits wide so saturation is reached in a few hundred
// back-to-back reads.
// ----------------------------------------------------------------------------
module tb_apb_slave_responder;

   localparam int          AW    = 32;
   localparam int          DW    = 32;
   localparam int          DEPTH = 16;
   localparam logic [31:0] BASE  = 32'h0000_1000;
   localparam int          CW    = 8;

   logic          clk;
   logic          rst;
   logic          psel;
   logic          penable;
   logic          pwrite;
   logic [AW-1:0] paddr;
   logic [DW-1:0] pwdata;
   logic [3:0]    cfg_wait;
   logic [DW-1:0] prdata;
   logic          pready;
   logic          pslverr;
   logic [CW-1:0] wr_cnt;
   logic [CW-1:0] rd_cnt;
   logic [CW-1:0] err_cnt;

   int tests_run    = 0;
   int tests_failed = 0;
   int cyc_cnt      = 0;
   int exp_wr       = 0;
   int exp_rd       = 0;
   int exp_err      = 0;

   apb_slave_responder #(
      .ADDR_WIDTH(AW),
      .DATA_WIDTH(DW),
      .DEPTH     (DEPTH),
      .BASE_ADDR (BASE),
      .CNT_WIDTH (CW)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .psel    (psel),
      .penable (penable),
      .pwrite  (pwrite),
      .paddr   (paddr),
      .pwdata  (pwdata),
      .cfg_wait(cfg_wait),
      .prdata  (prdata),
      .pready  (pready),
      .pslverr (pslverr),
      .wr_cnt  (wr_cnt),
      .rd_cnt  (rd_cnt),
      .err_cnt (err_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   // One APB transfer. Called and returns at 1 time unit after a rising edge;
   // the returning edge is the completion edge, so a following call issues
   // its setup phase back-to-back. cfg_wait is scrambled during the access
   // phase to show it is only sampled in the setup cycle.
   task automatic apb_xfer(input logic wr, input logic [31:0] a, input logic [31:0] d,
                           output logic [31:0] rd, output logic er, output int cyc);
      logic [3:0] saved;
      logic       got;
      logic       idle_bad;
      rd       = '0;
      er       = 1'b0;
      cyc      = 0;
      got      = 1'b0;
      idle_bad = 1'b0;
      saved    = cfg_wait;
      psel     = 1'b1;
      penable  = 1'b0;
      pwrite   = wr;
      paddr    = a;
      pwdata   = d;
      @(posedge clk); #1;
      penable  = 1'b1;
      cfg_wait = ~saved;
      for (int i = 0; i < 40 && !got; i++) begin
         @(negedge clk);
         cyc++;
         if (pready === 1'b1) begin
            rd  = prdata;
            er  = pslverr;
            got = 1'b1;
         end else if (prdata !== '0 || pslverr !== 1'b0) begin
            idle_bad = 1'b1;
         end
         @(posedge clk); #1;
      end
      psel     = 1'b0;
      penable  = 1'b0;
      cfg_wait = saved;
      tests_run++;
      if (!got) begin
         tests_failed++;
         $display("FAIL xfer_timeout addr=%h: pready never seen within %0d cycles", a, cyc);
      end
      tests_run++;
      if (idle_bad) begin
         tests_failed++;
         $display("FAIL idle_outputs addr=%h: prdata/pslverr nonzero while pready=0", a);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      tests_run++;
      if ({pready, pslverr, prdata, wr_cnt, rd_cnt, err_cnt} !== '0) begin
         tests_failed++;
         $display("FAIL reset_outputs: pready=%b pslverr=%b prdata=%h wr=%0d rd=%0d err=%0d required all 0",
                  pready, pslverr, prdata, wr_cnt, rd_cnt, err_cnt);
      end
      #2 rst = 1'b0;
      @(posedge clk); #1;
      $display("[TB] reset done");
   endtask

   task automatic test_zero_wait();
      logic [31:0] rd;
      logic        er;
      int          cyc;
      logic        bad;
      cfg_wait = 4'd0;
      apb_xfer(1'b1, BASE + 32'h8, 32'hDEAD_BEEF, rd, er, cyc);
      exp_wr++;
      $display("[TB] write %h <= %h cycles=%0d err=%b", BASE + 32'h8, 32'hDEAD_BEEF, cyc, er);
      tests_run++;
      if (cyc !== 1 || er !== 1'b0 || rd !== 32'h0) begin
         tests_failed++;
         $display("FAIL zw_write: cycles=%0d err=%b prdata=%h required 1/0/0", cyc, er, rd);
      end
      apb_xfer(1'b0, BASE + 32'h8, 32'h0, rd, er, cyc);
      exp_rd++;
      $display("[TB] read  %h => %h cycles=%0d err=%b", BASE + 32'h8, rd, cyc, er);
      tests_run++;
      if (cyc !== 1 || er !== 1'b0 || rd !== 32'hDEAD_BEEF) begin
         tests_failed++;
         $display("FAIL zw_read: cycles=%0d err=%b prdata=%h required 1/0/deadbeef", cyc, er, rd);
      end
      tests_run++;
      if (wr_cnt !== 8'd1 || rd_cnt !== 8'd1) begin
         tests_failed++;
         $display("FAIL zw_counters: wr=%0d rd=%0d required 1/1", wr_cnt, rd_cnt);
      end
      // psel and penable high together in IDLE must be ignored
      bad     = 1'b0;
      psel    = 1'b1;
      penable = 1'b1;
      pwrite  = 1'b1;
      paddr   = BASE;
      pwdata  = 32'hFFFF_FFFF;
      repeat (3) begin
         @(negedge clk);
         if (pready !== 1'b0) bad = 1'b1;
      end
      @(posedge clk); #1;
      psel    = 1'b0;
      penable = 1'b0;
      @(posedge clk); #1;
      $display("[TB] protocol violation psel+penable in IDLE, pready seen=%b", bad);
      tests_run++;
      if (bad || wr_cnt !== 8'd1 || err_cnt !== 8'd0) begin
         tests_failed++;
         $display("FAIL violation_ignored: pready_seen=%b wr=%0d err=%0d required 0/1/0", bad, wr_cnt, err_cnt);
      end
   endtask

   task automatic test_wait_states();
      logic [31:0] rd;
      logic        er;
      int          cyc;
      cfg_wait = 4'd3;
      apb_xfer(1'b0, BASE, 32'h0, rd, er, cyc);
      exp_rd++;
      $display("[TB] read  %h => %h cycles=%0d err=%b", BASE, rd, cyc, er);
      tests_run++;
      if (cyc !== 4 || rd !== 32'h0) begin
         tests_failed++;
         $display("FAIL ws_read_before: cycles=%0d prdata=%h required 4/0", cyc, rd);
      end
      apb_xfer(1'b1, BASE, 32'h1234_5678, rd, er, cyc);
      exp_wr++;
      $display("[TB] write %h <= %h cycles=%0d err=%b", BASE, 32'h1234_5678, cyc, er);
      tests_run++;
      if (cyc !== 4 || er !== 1'b0) begin
         tests_failed++;
         $display("FAIL ws_write: cycles=%0d err=%b required 4/0", cyc, er);
      end
      apb_xfer(1'b0, BASE, 32'h0, rd, er, cyc);
      exp_rd++;
      $display("[TB] read  %h => %h cycles=%0d err=%b", BASE, rd, cyc, er);
      tests_run++;
      if (cyc !== 4 || rd !== 32'h1234_5678) begin
         tests_failed++;
         $display("FAIL ws_read_after: cycles=%0d prdata=%h required 4/12345678", cyc, rd);
      end
   endtask

   task automatic test_errors();
      logic [31:0] rd;
      logic [31:0] addrs [3];
      logic        wrs   [3];
      logic        er;
      int          cyc;
      addrs[0] = BASE + 32'd64;  wrs[0] = 1'b0;   // past the window
      addrs[1] = BASE + 32'h2;   wrs[1] = 1'b1;   // misaligned
      addrs[2] = BASE - 32'h4;   wrs[2] = 1'b0;   // below the base
      cfg_wait = 4'd0;
      for (int i = 0; i < 3; i++) begin
         apb_xfer(wrs[i], addrs[i], 32'hFFFF_FFFF, rd, er, cyc);
         exp_err++;
         $display("[TB] %s %h cycles=%0d err=%b prdata=%h", wrs[i] ? "write" : "read ", addrs[i], cyc, er, rd);
         tests_run++;
         if (cyc !== 1 || er !== 1'b1 || rd !== 32'h0) begin
            tests_failed++;
            $display("FAIL err_resp%0d: cycles=%0d err=%b prdata=%h required 1/1/0", i, cyc, er, rd);
         end
      end
      tests_run++;
      if (err_cnt !== 8'(exp_err) || wr_cnt !== 8'(exp_wr) || rd_cnt !== 8'(exp_rd)) begin
         tests_failed++;
         $display("FAIL err_counters: err=%0d wr=%0d rd=%0d required %0d/%0d/%0d",
                  err_cnt, wr_cnt, rd_cnt, exp_err, exp_wr, exp_rd);
      end
      apb_xfer(1'b0, BASE, 32'h0, rd, er, cyc);
      exp_rd++;
      $display("[TB] read  %h => %h cycles=%0d err=%b", BASE, rd, cyc, er);
      tests_run++;
      if (rd !== 32'h1234_5678 || er !== 1'b0) begin
         tests_failed++;
         $display("FAIL err_no_write: prdata=%h err=%b required 12345678/0", rd, er);
      end
   endtask

   task automatic test_abort();
      logic [31:0] rd;
      logic        er;
      int          cyc;
      logic        bad;
      cfg_wait = 4'd0;
      apb_xfer(1'b1, BASE + 32'h4, 32'h1111_2222, rd, er, cyc);
      exp_wr++;
      $display("[TB] write %h <= %h cycles=%0d err=%b", BASE + 32'h4, 32'h1111_2222, cyc, er);
      cfg_wait = 4'd5;
      bad      = 1'b0;
      psel     = 1'b1;
      penable  = 1'b0;
      pwrite   = 1'b1;
      paddr    = BASE + 32'h4;
      pwdata   = 32'hAAAA_5555;
      @(posedge clk); #1;
      penable  = 1'b1;
      repeat (2) begin
         @(negedge clk);
         if (pready !== 1'b0) bad = 1'b1;
         @(posedge clk); #1;
      end
      psel     = 1'b0;
      penable  = 1'b0;
      @(posedge clk); #1;
      $display("[TB] abort write %h after 2 access cycles, pready seen=%b", BASE + 32'h4, bad);
      tests_run++;
      if (bad || wr_cnt !== 8'(exp_wr) || rd_cnt !== 8'(exp_rd) || err_cnt !== 8'(exp_err)) begin
         tests_failed++;
         $display("FAIL abort_counters: pready_seen=%b wr=%0d rd=%0d err=%0d required 0/%0d/%0d/%0d",
                  bad, wr_cnt, rd_cnt, err_cnt, exp_wr, exp_rd, exp_err);
      end
      cfg_wait = 4'd0;
      apb_xfer(1'b0, BASE + 32'h4, 32'h0, rd, er, cyc);
      exp_rd++;
      $display("[TB] read  %h => %h cycles=%0d err=%b", BASE + 32'h4, rd, cyc, er);
      tests_run++;
      if (rd !== 32'h1111_2222 || cyc !== 1) begin
         tests_failed++;
         $display("FAIL abort_old_value: prdata=%h cycles=%0d required 11112222/1", rd, cyc);
      end
   endtask

   task automatic test_reset_mid();
      logic [31:0] rd;
      logic        er;
      int          cyc;
      cfg_wait = 4'd7;
      psel     = 1'b1;
      penable  = 1'b0;
      pwrite   = 1'b1;
      paddr    = BASE + 32'hC;
      pwdata   = 32'h5555_AAAA;
      @(posedge clk); #1;
      penable  = 1'b1;
      @(posedge clk); #2;
      rst      = 1'b1;
      #1;
      $display("[TB] reset mid-access: pready=%b pslverr=%b prdata=%h wr=%0d rd=%0d err=%0d",
               pready, pslverr, prdata, wr_cnt, rd_cnt, err_cnt);
      tests_run++;
      if ({pready, pslverr, prdata, wr_cnt, rd_cnt, err_cnt} !== '0) begin
         tests_failed++;
         $display("FAIL midreset_outputs: pready=%b pslverr=%b prdata=%h wr=%0d rd=%0d err=%0d required all 0",
                  pready, pslverr, prdata, wr_cnt, rd_cnt, err_cnt);
      end
      psel    = 1'b0;
      penable = 1'b0;
      #2 rst  = 1'b0;
      @(posedge clk); #1;
      exp_wr   = 0;
      exp_rd   = 0;
      exp_err  = 0;
      cfg_wait = 4'd0;
      for (int i = 0; i < DEPTH; i++) begin
         apb_xfer(1'b0, BASE + 32'(4 * i), 32'h0, rd, er, cyc);
         exp_rd++;
         $display("[TB] read  %h => %h cycles=%0d err=%b", BASE + 32'(4 * i), rd, cyc, er);
         tests_run++;
         if (rd !== 32'h0 || er !== 1'b0) begin
            tests_failed++;
            $display("FAIL midreset_reg%0d: prdata=%h err=%b required 0/0", i, rd, er);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] rd;
      logic        er;
      int          cyc;
      int          t0;
      cfg_wait = 4'd0;
      for (int i = 0; i < (1 << CW) + 4; i++) begin
         t0 = cyc_cnt;
         apb_xfer(1'b0, BASE + 32'(4 * (i % DEPTH)), 32'h0, rd, er, cyc);
         if (exp_rd < (1 << CW) - 1) exp_rd++;
         $display("[TB] b2b read %0d addr=%h => %h cycles=%0d rd_cnt=%0d", i,
                  BASE + 32'(4 * (i % DEPTH)), rd, cyc_cnt - t0, rd_cnt);
         tests_run++;
         if (cyc_cnt - t0 !== 2 || rd !== 32'h0 || rd_cnt !== 8'(exp_rd)) begin
            tests_failed++;
            $display("FAIL b2b_%0d: cycles=%0d prdata=%h rd_cnt=%0d required 2/0/%0d",
                     i, cyc_cnt - t0, rd, rd_cnt, exp_rd);
         end
      end
      tests_run++;
      if (rd_cnt !== 8'hFF || wr_cnt !== 8'd0 || err_cnt !== 8'd0) begin
         tests_failed++;
         $display("FAIL b2b_saturate: rd=%0d wr=%0d err=%0d required 255/0/0", rd_cnt, wr_cnt, err_cnt);
      end
   endtask

   initial begin
      rst      = 1'b1;
      psel     = 1'b0;
      penable  = 1'b0;
      pwrite   = 1'b0;
      paddr    = '0;
      pwdata   = '0;
      cfg_wait = 4'd0;
      test_reset();
      test_zero_wait();
      test_wait_states();
      test_errors();
      test_abort();
      test_reset_mid();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule

// File: doc/apb_slave_responder.md
Name: apb_slave_responder

Overview:
- APB3 completer: the responding end of the APB buses that the bridge drives out of its master ports.
- Contains a word-addressed register bank, a programmable wait-state generator and PSLVERR generation for bad addresses.
- Keeps saturating per-transfer statistics counters.
- Used as the downstream peripheral model and as the synthesizable endpoint behind each APB output channel.

Parameters:
- ADDR_WIDTH, 32, width of paddr.
- DATA_WIDTH, 32, width of pwdata/prdata; must be 32.
- DEPTH, 16, number of 32-bit registers; power of two, 2..256.
- BASE_ADDR, 32'h0000_0000, byte address of register 0; aligned to DEPTH*4.
- CNT_WIDTH, 16, width of the statistics counters.

Ports:
- clk  input  1  single clock; all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- psel  input  1  APB select.
- penable  input  1  APB enable (access phase).
- pwrite  input  1  1 = write, 0 = read.
- paddr  input  ADDR_WIDTH  byte address.
- pwdata  input  DATA_WIDTH  write data.
- cfg_wait  input  4  wait states to insert; sampled in the setup cycle.
- prdata  output  DATA_WIDTH  read data.
- pready  output  1  transfer completes this cycle.
- pslverr  output  1  error response; valid only with pready.
- wr_cnt  output  CNT_WIDTH  successful writes.
- rd_cnt  output  CNT_WIDTH  successful reads.
- err_cnt  output  CNT_WIDTH  error responses.

Behaviour:
- Reset (async, rst=1): state=IDLE, wait counter=0, all registers=0, prdata=0, pready=0, pslverr=0, counters=0. Reset asserted mid-transfer aborts it with no register update.
- FSM has two states, IDLE and ACCESS.
- IDLE, psel=1 and penable=0 (setup cycle):
  - latch pwrite, paddr, pwdata and cfg_wait into wcnt;
  - next state ACCESS.
- IDLE, psel=1 and penable=1 (protocol violation): ignored; stay IDLE, pready=0.
- ACCESS, psel=0: master abort. Go to IDLE; no commit, no counter update.
- ACCESS, wcnt!=0: wcnt decrements; pready=0.
- ACCESS, wcnt==0: pready=1 combinationally from state and wcnt; transfer completes this cycle; next state IDLE.
- Latency: cfg_wait=N gives N+1 access-phase cycles. N=0 means zero-wait, with pready=1 in the first penable cycle.
- Address decode uses the latched address:
  - off = addr - BASE_ADDR; idx = off[log2(DEPTH)+1:2].
  - Error if addr < BASE_ADDR, off >= DEPTH*4, or addr[1:0]!=0.
- Completion cycle, good address:
  - write: reg[idx] <= latched pwdata at the clock edge;
  - read: prdata = reg[idx].
- Completion cycle, error:
  - pslverr=1, no register write, prdata=0.
- prdata is 0 whenever pready=0 or pwrite=1. pslverr is 0 whenever pready=0.
- Back-to-back transfers: the cycle after completion is IDLE, so a setup phase presented there is accepted normally. Throughput is one transfer per 2+N cycles.
- Counters update on the completion edge:
  - err_cnt increments on pslverr;
  - otherwise wr_cnt or rd_cnt increments;
  - each saturates at all-ones and does not wrap.
- A read after a write to the same index returns the new data. The write commits at its completion edge, before any later setup cycle.
- cfg_wait changes during ACCESS have no effect on the current transfer.

Test Plan:
- Reset, then cfg_wait=0; write 32'hDEAD_BEEF to BASE+0x8, then read BASE+0x8 → each access phase 1 cycle with pready=1; prdata=32'hDEAD_BEEF; wr_cnt=1, rd_cnt=1.
- cfg_wait=3; write 32'h1234_5678 to BASE+0x0 → pready low for 3 access cycles, high on the 4th; the register updates only at that edge.
- Read BASE+DEPTH*4 (out of range), then write BASE+0x2 (misaligned) → each response pready=1, pslverr=1, prdata=0; err_cnt=2; no register changes.
- cfg_wait=5 write to BASE+0x4, psel dropped after 2 access cycles → FSM returns to IDLE; reg[1] unchanged; counters unchanged. The next normal read returns the old value.
- Assert rst mid-ACCESS of a write with cfg_wait=7 → outputs go to 0 immediately; after release, every register reads 0.
- 65540 back-to-back zero-wait reads with CNT_WIDTH=16 → rd_cnt saturates at 16'hFFFF; each transfer takes 2 cycles.
